// File: rtl/interrupt_rr_scheduler.sv
// interrupt_rr_scheduler: round-robin interrupt scheduler with per-source mask and done handshake
module interrupt_rr_scheduler #(
   parameter int NINTR = 4,
   localparam int IDW = (NINTR > 1) ? $clog2(NINTR) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NINTR-1:0] req,
   input  logic [NINTR-1:0] mask,
   input  logic             done,
   output logic [NINTR-1:0] ack,
   output logic [IDW-1:0]   id,
   output logic             irq,
   output logic [NINTR-1:0] pending
);
   typedef enum logic [1:0] {IDLE, SERVICE, RELEASE} state_t;
   state_t           state, state_nx;
   logic [IDW-1:0]   ptr, ptr_nx, id_nx, sel;
   logic [NINTR-1:0] elig, clr, ack_nx, pending_nx;
   logic             irq_nx, found;
   function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      return IDW'((s >= NINTR) ? s - NINTR : s);
   endfunction
   // first eligible source at or above ptr, wrapping past the top index
   always_comb begin
      elig = (pending | req) & ~mask;
      sel = '0;
      found = 1'b0;
      for (int i = 0; i < NINTR; i++) begin
         if (!found && elig[wrap_idx(int'(ptr), i)]) begin
            sel = wrap_idx(int'(ptr), i);
            found = 1'b1;
         end
      end
   end
   // grant/service/release sequencing and next register values
   always_comb begin
      state_nx = state;
      ack_nx = ack;
      id_nx = id;
      irq_nx = irq;
      ptr_nx = ptr;
      clr = '0;
      case (state)
         IDLE: begin
            if (found) begin
               ack_nx = (NINTR)'(1) << sel;
               clr = (NINTR)'(1) << sel;
               id_nx = sel;
               irq_nx = 1'b1;
               state_nx = SERVICE;
            end
         end
         SERVICE: begin
            if (done) begin
               ack_nx = '0;
               irq_nx = 1'b0;
               ptr_nx = (id == IDW'(NINTR - 1)) ? '0 : id + 1'b1;
               state_nx = RELEASE;
            end
         end
         default: state_nx = IDLE;
      endcase
      pending_nx = (pending | req) & ~clr;
   end
   // state and output registers; reset discards all latched requests
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         ack <= '0;
         id <= '0;
         irq <= 1'b0;
         ptr <= '0;
         pending <= '0;
      end else begin
         state <= state_nx;
         ack <= ack_nx;
         id <= id_nx;
         irq <= irq_nx;
         ptr <= ptr_nx;
         pending <= pending_nx;
      end
   end
endmodule

// File: tb/tb_interrupt_rr_scheduler.sv
// tb_interrupt_rr_scheduler: directed and randomized checks of the round-robin interrupt scheduler
module tb_interrupt_rr_scheduler;
   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] mask;
   logic       done;
   logic [3:0] ack;
   logic [1:0] id;
   logic       irq;
   logic [3:0] pending;
   int checks = 0;
   int errors = 0;
   logic [3:0] m_pend;
   int         m_ptr, m_id;
   bit         m_busy, m_release;

   interrupt_rr_scheduler #(.NINTR(4)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .mask(mask), .done(done),
      .ack(ack), .id(id), .irq(irq), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic reset_model();
      m_pend = 4'b0;
      m_ptr = 0;
      m_id = 0;
      m_busy = 0;
      m_release = 0;
   endtask

   // drive one cycle of inputs, advance the reference model across the edge, settle 1 time unit
   task automatic step(input logic [3:0] r, input logic [3:0] m, input logic d);
      logic [3:0] elig;
      logic [3:0] clr;
      req = r;
      mask = m;
      done = d;
      @(posedge clk);
      elig = (m_pend | r) & ~m;
      clr = 4'b0;
      if (m_release) m_release = 0;
      else if (m_busy) begin
         if (d) begin
            m_busy = 0;
            m_release = 1;
            m_ptr = (m_id + 1) % 4;
         end
      end else if (elig != 4'b0) begin
         for (int i = 0; i < 4; i++) begin
            if (elig[(m_ptr + i) % 4]) begin
               m_id = (m_ptr + i) % 4;
               break;
            end
         end
         m_busy = 1;
         clr[m_id] = 1'b1;
      end
      m_pend = (m_pend | r) & ~clr;
      #1;
   endtask

   task automatic finish_service();
      step(4'b0, 4'b0, 1'b1);
      step(4'b0, 4'b0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({ack, id, irq, pending} !== 11'b0) begin errors++; $display("FAIL reset_init: ack=%b id=%0d irq=%b pending=%b required all zero", ack, id, irq, pending); end
      reset_n = 1'b1;
      reset_model();
      step(4'b0100, 4'b0, 1'b0);
      step(4'b0011, 4'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({ack, id, irq, pending} !== 11'b0) begin errors++; $display("FAIL reset_async: ack=%b id=%0d irq=%b pending=%b required all zero", ack, id, irq, pending); end
      reset_model();
      #1 reset_n = 1'b1;
      step(4'b1000, 4'b0, 1'b0);
      checks++; if (ack !== 4'b1000 || id !== 2'd3 || irq !== 1'b1 || pending !== 4'b0) begin errors++; $display("FAIL reset_regrant: ack=%b id=%0d irq=%b pending=%b required 1000/3/1/0000", ack, id, irq, pending); end
      finish_service();
   endtask

   task automatic test_single_pulse();
      step(4'b0100, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0100 || id !== 2'd2 || irq !== 1'b1 || pending !== 4'b0) begin errors++; $display("FAIL single_grant: ack=%b id=%0d irq=%b pending=%b required 0100/2/1/0000", ack, id, irq, pending); end
      repeat (5) begin
         step(4'b0, 4'b0, 1'b0);
         checks++; if (irq !== 1'b1 || ack !== 4'b0100) begin errors++; $display("FAIL single_hold: irq=%b ack=%b required 1/0100", irq, ack); end
      end
      step(4'b0, 4'b0, 1'b1);
      checks++; if (ack !== 4'b0 || irq !== 1'b0 || id !== 2'd2) begin errors++; $display("FAIL single_done: ack=%b irq=%b id=%0d required 0000/0/2", ack, irq, id); end
      step(4'b0, 4'b0, 1'b0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_release: irq=%b required 0", irq); end
      step(4'b1100, 4'b0, 1'b0);
      checks++; if (ack !== 4'b1000 || id !== 2'd3 || pending !== 4'b0100) begin errors++; $display("FAIL single_ptr3: ack=%b id=%0d pending=%b required 1000/3/0100", ack, id, pending); end
      finish_service();
      step(4'b0, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0100 || id !== 2'd2) begin errors++; $display("FAIL single_drain: ack=%b id=%0d required 0100/2", ack, id); end
      finish_service();
   endtask

   task automatic test_wrap();
      step(4'b0101, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0001 || id !== 2'd0 || pending !== 4'b0100) begin errors++; $display("FAIL wrap_first: ack=%b id=%0d pending=%b required 0001/0/0100", ack, id, pending); end
      finish_service();
      step(4'b0, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0100 || id !== 2'd2 || pending !== 4'b0) begin errors++; $display("FAIL wrap_second: ack=%b id=%0d pending=%b required 0100/2/0000", ack, id, pending); end
      finish_service();
      step(4'b1001, 4'b0, 1'b0);
      checks++; if (ack !== 4'b1000 || id !== 2'd3) begin errors++; $display("FAIL wrap_ptr3: ack=%b id=%0d required 1000/3", ack, id); end
      finish_service();
      step(4'b0, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0001 || id !== 2'd0) begin errors++; $display("FAIL wrap_drain: ack=%b id=%0d required 0001/0", ack, id); end
      finish_service();
   endtask

   task automatic test_burst();
      logic [3:0] e;
      step(4'b1000, 4'b0, 1'b0);
      finish_service();
      step(4'b1111, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0001 || id !== 2'd0 || pending !== 4'b1110) begin errors++; $display("FAIL burst_first: ack=%b id=%0d pending=%b required 0001/0/1110", ack, id, pending); end
      for (int k = 1; k < 4; k++) begin
         e = 4'(1 << k);
         step(4'b0, 4'b0, 1'b1);
         checks++; if (irq !== 1'b0) begin errors++; $display("FAIL burst_gap1: k=%0d irq=%b required 0", k, irq); end
         step(4'b0, 4'b0, 1'b0);
         checks++; if (irq !== 1'b0) begin errors++; $display("FAIL burst_gap2: k=%0d irq=%b required 0", k, irq); end
         step(4'b0, 4'b0, 1'b0);
         checks++; if (ack !== e || id !== 2'(k) || irq !== 1'b1) begin errors++; $display("FAIL burst_grant: k=%0d ack=%b id=%0d irq=%b required %b/%0d/1", k, ack, id, irq, e, k); end
      end
      finish_service();
      checks++; if (pending !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL burst_end: pending=%b irq=%b required 0000/0", pending, irq); end
   endtask

   task automatic test_mask();
      step(4'b0001, 4'b0001, 1'b0);
      checks++; if (irq !== 1'b0 || pending !== 4'b0001) begin errors++; $display("FAIL mask_latch: irq=%b pending=%b required 0/0001", irq, pending); end
      step(4'b0, 4'b0001, 1'b0);
      checks++; if (irq !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL mask_hold: irq=%b ack=%b required 0/0000", irq, ack); end
      step(4'b0, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0001 || pending !== 4'b0 || irq !== 1'b1) begin errors++; $display("FAIL mask_release: ack=%b pending=%b irq=%b required 0001/0000/1", ack, pending, irq); end
      finish_service();
   endtask

   task automatic test_rerequest();
      step(4'b0010, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0010 || id !== 2'd1) begin errors++; $display("FAIL rereq_grant: ack=%b id=%0d required 0010/1", ack, id); end
      step(4'b0010, 4'b0010, 1'b0);
      checks++; if (pending !== 4'b0010 || ack !== 4'b0010 || irq !== 1'b1) begin errors++; $display("FAIL rereq_latch: pending=%b ack=%b irq=%b required 0010/0010/1", pending, ack, irq); end
      step(4'b0, 4'b0, 1'b1);
      checks++; if (ack !== 4'b0 || irq !== 1'b0) begin errors++; $display("FAIL rereq_done: ack=%b irq=%b required 0000/0", ack, irq); end
      step(4'b0, 4'b0, 1'b0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rereq_release: irq=%b required 0", irq); end
      step(4'b0, 4'b0, 1'b0);
      checks++; if (ack !== 4'b0010 || id !== 2'd1 || pending !== 4'b0) begin errors++; $display("FAIL rereq_regrant: ack=%b id=%0d pending=%b required 0010/1/0000", ack, id, pending); end
      finish_service();
   endtask

   task automatic test_done_ignored();
      step(4'b0, 4'b0, 1'b1);
      checks++; if (irq !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL done_idle: irq=%b ack=%b required 0/0000", irq, ack); end
      step(4'b0100, 4'b0, 1'b1);
      checks++; if (irq !== 1'b1 || ack !== 4'b0100) begin errors++; $display("FAIL done_on_grant: irq=%b ack=%b required 1/0100", irq, ack); end
      step(4'b0, 4'b0, 1'b0);
      checks++; if (irq !== 1'b1 || ack !== 4'b0100) begin errors++; $display("FAIL done_after_grant: irq=%b ack=%b required 1/0100", irq, ack); end
      finish_service();
   endtask

   task automatic test_random();
      logic [3:0] r, m, e_ack;
      logic d;
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
         m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         d = ($urandom_range(0, 2) == 0);
         step(r, m, d);
         e_ack = m_busy ? 4'(1 << m_id) : 4'b0;
         checks++; if (ack !== e_ack) begin errors++; $display("FAIL rand_ack: n=%0d ack=%b required %b", n, ack, e_ack); end
         checks++; if (id !== 2'(m_id)) begin errors++; $display("FAIL rand_id: n=%0d id=%0d required %0d", n, id, m_id); end
         checks++; if (irq !== m_busy) begin errors++; $display("FAIL rand_irq: n=%0d irq=%b required %b", n, irq, m_busy); end
         checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending: n=%0d pending=%b required %b", n, pending, m_pend); end
         checks++; if ((irq && ack == 4'b0) || $countones(ack) > 1) begin errors++; $display("FAIL rand_invariant: n=%0d irq=%b ack=%b", n, irq, ack); end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      req = 4'b0;
      mask = 4'b0;
      done = 1'b0;
      reset_model();
      test_reset();
      test_single_pulse();
      test_wrap();
      test_burst();
      test_mask();
      test_rerequest();
      test_done_ignored();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/interrupt_rr_scheduler.md
# interrupt_rr_scheduler

Round-robin interrupt scheduler that latches pulsed interrupt requests, applies a per-source mask, and grants one source at a time to the CPU via a one-hot `ack`, a binary `id` and a level `irq` held until `done`. It sits between the peripheral request lines and the processor interrupt input. It is the fair-share counterpart to the fixed-priority interrupt controller: no source can starve another.

## Interface
- `NINTR`, default 4: number of interrupt sources, ≥1.
- `IDW`, default `$clog2(NINTR)` (min 1): width of `id` and of the round-robin pointer; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NINTR  interrupt request pulses or levels, sampled every edge.
- `mask`  in  NINTR  1 = source disabled for granting; it still latches into pending.
- `done`  in  1  CPU end-of-service strobe; honoured only in SERVICE.
- `ack`  out  NINTR  one-hot grant, registered.
- `id`  out  IDW  index of granted source, registered.
- `irq`  out  1  interrupt to CPU, registered; high exactly while in SERVICE.
- `pending`  out  NINTR  latched, not-yet-granted requests, registered.

## Operation
- Reset values: `ack`=0, `id`=0, `irq`=0, `pending`=0, pointer `ptr`=0, state IDLE.
- Pending update every edge, in all states: `pending <= (pending | req) & ~clr`.
  - `clr` is the one-hot grant issued on that edge, else 0.
  - If `req[k]` is high on the edge that grants k, that request is consumed by the grant and not re-latched.
  - `req[k]` high on any later edge re-latches bit k, including while k is in service.
- Eligible vector: `elig = (pending | req) & ~mask`.
- Arbitration: select the first set bit of `elig` searching upward from `ptr` and wrapping at NINTR-1 to 0. Indices ≥ NINTR never occur.
- States:
  - IDLE: if `elig`≠0, then on that edge `ack <= onehot(sel)`, `id <= sel`, `irq <= 1`, `clr = onehot(sel)`, and go to SERVICE. Otherwise stay.
  - SERVICE: hold `ack`/`id`/`irq`. `mask` and `req` changes do not revoke the grant.
    - On `done`=1: `ack <= 0`, `irq <= 0`, and `ptr <= (id==NINTR-1) ? 0 : id+1`. `id` holds its last value. Go to RELEASE.
  - RELEASE: unconditionally go to IDLE. No grant is issued.
- `done` in IDLE or RELEASE is ignored.
- `NINTR`=1: `ptr` stays 0 and `id` stays 0.
- Asynchronous reset in any state, including mid-service, returns every register to its reset value. All latched requests are discarded.

## Timing
- Request to grant: `req[k]` high at edge N while in IDLE, eligible, and winning arbitration → `ack`/`irq` high after edge N. Latency is 1 edge.
- Masked request: `pending[k]`=1 after edge N. Grant follows the first IDLE edge after `mask[k]` falls.
- Service end: `done` at edge M → `irq`/`ack` low after M, RELEASE during M to M+1, IDLE at M+1. The earliest next grant is at edge M+2, so `irq` is low for at least 2 cycles between grants.
- `done` on the same edge that the grant is issued is not honoured. `done` must be seen while in SERVICE.
- `irq` is never high while `ack`=0, and `ack` never has more than one bit set.

## Test plan
- Reset: assert `reset_n`=0 mid-sequence → `ack`=0, `id`=0, `irq`=0, `pending`=0 immediately. After release, `req`=4'b1000 grants source 3 (`ptr` was reset to 0).
- Single pulse: IDLE, `ptr`=0, `req`=4'b0100 for one cycle → next edge `ack`=4'b0100, `id`=2, `irq`=1, `pending`=0. Hold `irq` for 5 cycles with `done`=0. Then `done` pulse → `ack`=0, `irq`=0, `ptr`=3.
- Burst fairness: `ptr`=0, `req`=4'b1111 for one cycle → `pending`=4'b1110 after the grant of 0. With `done` pulsed each service, grants are 0, 1, 2, 3, each separated by ≥2 `irq`-low cycles.
- Wrap: `ptr`=3, `req`=4'b0101 → grant 0 first, then 2. Then `ptr`=3.
- Mask: `mask`=4'b0001, `req`=4'b0001 pulse → `irq` stays 0 and `pending`=4'b0001. Drop `mask` → `ack`=4'b0001 on the next edge and `pending`=0.
- Re-request in service: while `ack`=4'b0010, pulse `req`=4'b0010 → `pending`=4'b0010 and the grant is unchanged. After `done`, with `ptr`=2 and no other requests, source 1 is re-granted at edge M+2.
